// File: rtl/voice_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : voice_mixer
//  Purpose  : Mixes VOICES 1-bit oscillator waves into one PWM audio output.
//             The voice popcount is integrated over each PWM period, scaled
//             by a 4-bit master volume, slew-limited to suppress clicks and
//             then used as the duty cycle of a single-pin PWM DAC.
//  Ports    :
//    clk_i         in   1         system clock
//    nrst_i        in   1         asynchronous active-low reset
//    oscIn_i       in   VOICES    oscillator waves, synchronous to clk_i
//    volume_i      in   4         master volume, 0 = silent, 15 = max
//    mute_i        in   1         force target level to 0 (still slewed)
//    pwm_o         out  1         PWM audio output
//    level_o       out  PWM_BITS  current duty value
//    periodStrb_o  out  1         1-cycle pulse when a new duty is latched
//  Revision : 1.0  initial release
// ============================================================================
module voice_mixer #(
    parameter int VOICES   = 4,   // power of two
    parameter int PWM_BITS = 8,   // period = 2**PWM_BITS clocks
    parameter int SLEW     = 4    // max duty step per period
) (
    input  logic                clk_i,
    input  logic                nrst_i,
    input  logic [VOICES-1:0]   oscIn_i,
    input  logic [3:0]          volume_i,
    input  logic                mute_i,
    output logic                pwm_o,
    output logic [PWM_BITS-1:0] level_o,
    output logic                periodStrb_o
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int LOG2V  = $clog2(VOICES);
    localparam int POP_W  = LOG2V + 1;            // holds 0..VOICES
    localparam int ACC_W  = PWM_BITS + LOG2V + 1; // holds 0..VOICES*2**PWM_BITS
    localparam int PROD_W = ACC_W + 4;            // level * volume

    localparam logic [PWM_BITS-1:0] C_CNT_MAX = '1;
    localparam logic [PWM_BITS-1:0] C_SLEW    = PWM_BITS'(SLEW);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PWM_BITS-1:0] cnt_q,  cnt_d;
    logic [ACC_W-1:0]    acc_q,  acc_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                pwm_q,  pwm_d;
    logic                strb_q, strb_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [POP_W-1:0]    pop_w;
    logic [ACC_W-1:0]    sum_w;
    logic [PWM_BITS-1:0] target_w;
    logic                lastCycle_w;

    assign lastCycle_w = (cnt_q == C_CNT_MAX);

    // Number of voices that are high in this clock.
    always_comb begin
        pop_w = '0;
        for (int i = 0; i < VOICES; i++) begin
            pop_w = pop_w + POP_W'(oscIn_i[i]);
        end
    end

    // Period integral including the current cycle's contribution; this is
    // the value S that is used on the last cycle of the period.
    assign sum_w = acc_q + ACC_W'(pop_w);

    // target = ((S >> LOG2V) * volume) >> 4. The divide by VOICES is done
    // before the multiply so the rounding matches the reference formula.
    // The result never exceeds 2**PWM_BITS*15/16, so the truncation to
    // PWM_BITS drops only zero bits.
    always_comb begin
        target_w = '0;
        if (!mute_i) begin
            target_w = PWM_BITS'(
                ((PROD_W'(sum_w >> LOG2V)) * PROD_W'(volume_i)) >> 4);
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        cnt_d  = cnt_q + 1'b1;     // wraps max -> 0 naturally
        acc_d  = sum_w;
        duty_d = duty_q;
        strb_d = lastCycle_w;      // high while cnt == 0
        // Uses the registered duty, so a duty latched at the period edge
        // governs the comparison starting at cnt == 0.
        pwm_d  = (cnt_q < duty_q);

        if (lastCycle_w) begin
            acc_d = '0;
            // Slew limiter: step at most C_SLEW towards the target. Both
            // differences are taken only in the direction that cannot
            // underflow.
            if (target_w > duty_q) begin
                if ((target_w - duty_q) <= C_SLEW) begin
                    duty_d = target_w;
                end else begin
                    duty_d = duty_q + C_SLEW;
                end
            end else begin
                if ((duty_q - target_w) <= C_SLEW) begin
                    duty_d = target_w;
                end else begin
                    duty_d = duty_q - C_SLEW;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            duty_q <= '0;
            pwm_q  <= 1'b0;
            strb_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
            strb_q <= strb_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign pwm_o        = pwm_q;
    assign level_o      = duty_q;
    assign periodStrb_o = strb_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_voice_mixer
//  Purpose  : Directed self-checking bench for voice_mixer with VOICES=4,
//             PWM_BITS=8, SLEW=4. Expected values are hand-computed.
//  Revision : 1.0  initial release
// ============================================================================
module tb_voice_mixer;

    logic       clk_i;
    logic       nrst_i;
    logic [3:0] oscIn_i;
    logic [3:0] volume_i;
    logic       mute_i;
    logic       pwm_o;
    logic [7:0] level_o;
    logic       periodStrb_o;

    int total;
    int bad;
    logic toggle_en;

    voice_mixer #(
        .VOICES   (4),
        .PWM_BITS (8),
        .SLEW     (4)
    ) u_dut (
        .clk_i        (clk_i),
        .nrst_i       (nrst_i),
        .oscIn_i      (oscIn_i),
        .volume_i     (volume_i),
        .mute_i       (mute_i),
        .pwm_o        (pwm_o),
        .level_o      (level_o),
        .periodStrb_o (periodStrb_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // oscIn_i[0] toggles every clock while enabled.
    always @(negedge clk_i) begin
        if (toggle_en) oscIn_i[0] = ~oscIn_i[0];
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge where the strobe is high (bounded).
    task automatic wait_strb();
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!periodStrb_o && n < 300);
        if (!periodStrb_o) check("strb_timeout", 0, 1);
    endtask

    // Count pwm_o highs over one full period starting at a strobe negedge;
    // ends on the next strobe negedge.
    task automatic count_pwm(output int n);
        n = 0;
        for (int i = 0; i < 256; i++) begin
            if (pwm_o) n++;
            @(negedge clk_i);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_i);
    endtask

    // Reset, release on a negedge, and return at the first strobe,
    // checking its distance from release.
    task automatic reset_and_first(input string tag);
        int n;
        nrst_i = 1'b0;
        idle(2);
        nrst_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!periodStrb_o && n < 300);
        check(tag, n, 256);
    endtask

    initial begin
        int n;
        int exp_lvl;
        total     = 0;
        bad       = 0;
        toggle_en = 1'b0;
        nrst_i    = 1'b0;
        oscIn_i   = 4'b1111;
        volume_i  = 4'd15;
        mute_i    = 1'b0;

        // ---- reset state --------------------------------------------------
        idle(3);
        check("rst_pwm",   pwm_o,        0);
        check("rst_level", level_o,      0);
        check("rst_strb",  periodStrb_o, 0);

        // ---- all voices, volume 15: ramp towards 240 ----------------------
        nrst_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!periodStrb_o && n < 300);
        check("first_strb_dist", n, 256);
        check("ramp1_level", level_o, 4);
        for (int k = 2; k <= 15; k++) wait_strb();
        check("ramp15_level", level_o, 60);
        idle(30);
        check("pwm_high_cnt30", pwm_o, 1);

        // ---- async reset mid-period with duty 60 --------------------------
        #2 nrst_i = 1'b0;
        #1;
        check("midrst_pwm",   pwm_o,        0);
        check("midrst_level", level_o,      0);
        check("midrst_strb",  periodStrb_o, 0);
        @(negedge clk_i);
        nrst_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!periodStrb_o && n < 300);
        check("rel_strb_dist", n, 256);
        check("rel_level", level_o, 4);

        // ---- full ramp to 240 ---------------------------------------------
        for (int k = 2; k <= 60; k++) begin
            wait_strb();
            check("ramp_up", level_o, 4 * k);
        end
        wait_strb();
        check("settle_240", level_o, 240);
        count_pwm(n);
        check("pwm_highs_240", n, 240);

        // ---- mute: ramp down to 0 -----------------------------------------
        mute_i = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            wait_strb();
            check("mute_down", level_o, 240 - 4 * k);
        end
        count_pwm(n);
        check("pwm_highs_0", n, 0);
        check("muted_level", level_o, 0);
        mute_i = 1'b0;
        wait_strb();
        check("unmute_up", level_o, 4);

        // ---- one voice, volume 15: target 60 ------------------------------
        oscIn_i = 4'b0001;
        reset_and_first("v1_first_dist");
        check("v1_level1", level_o, 4);
        for (int k = 2; k <= 18; k++) begin
            wait_strb();
            exp_lvl = (4 * k > 60) ? 60 : 4 * k;
            check("v1_ramp", level_o, exp_lvl);
        end

        // ---- mid-period volume / mute changes are ignored -----------------
        idle(100);
        volume_i = 4'd0;
        idle(100);
        volume_i = 4'd15;
        wait_strb();
        check("vol_glitch_ignored", level_o, 60);
        idle(100);
        mute_i = 1'b1;
        idle(100);
        mute_i = 1'b0;
        wait_strb();
        check("mute_glitch_ignored", level_o, 60);
        // Volume 0 held across the boundary does take effect.
        volume_i = 4'd0;
        wait_strb();
        check("vol0_boundary", level_o, 56);
        volume_i = 4'd15;
        wait_strb();
        check("vol15_back", level_o, 60);

        // ---- toggling voice 0, volume 8: target 16 ------------------------
        oscIn_i   = 4'b0000;
        volume_i  = 4'd8;
        toggle_en = 1'b1;
        reset_and_first("tog_first_dist");
        check("tog_level1", level_o, 4);
        for (int k = 2; k <= 6; k++) begin
            wait_strb();
            exp_lvl = (4 * k > 16) ? 16 : 4 * k;
            check("tog_ramp", level_o, exp_lvl);
        end
        count_pwm(n);
        check("pwm_highs_16", n, 16);
        toggle_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
